// File: rtl/blft_win_sched.sv
// blft_win_sched: window-fetch scheduler for the bilateral filter.
// Walks the image raster one centre row at a time and issues one memory read per
// window pixel. Each column is fetched top to bottom. The returned pixels go to the
// window datapath, tagged with column-end, window-start and window-complete markers.
// Optional macro BLFT_BORDER_REPLICATE_EN: centres cover the whole image, and window
// rows/cols that fall outside it are clamped to the edge (replicated border).
module blft_win_sched #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int WIN   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dp_ready,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic        rd_ack,
    input  logic [7:0]  rd_data,
    output logic        pix_valid,
    output logic [7:0]  pix_data,
    output logic        pix_col_end,
    output logic        pix_win_start,
    output logic        ctr_valid,
    output logic [15:0] ctr_addr,
    output logic        busy,
    output logic        done
);

    localparam int H0 = (WIN - 1) / 2;

`ifdef BLFT_BORDER_REPLICATE_EN
    localparam int FIRST_CTR_ROW = 0;
    localparam int FIRST_CTR_COL = 0;
    localparam int LAST_CTR_ROW  = IMG_H - 1;
    localparam int LAST_CTR_COL  = IMG_W - 1;
    localparam logic signed [9:0] H0_S       = 10'(H0);
    localparam logic signed [9:0] ROW_MAX_S  = 10'(IMG_H - 1);
    localparam logic signed [9:0] COL_MAX_S  = 10'(IMG_W - 1);
    localparam logic        [7:0] ROW_MAX_8  = 8'(IMG_H - 1);
    localparam logic        [7:0] COL_MAX_8  = 8'(IMG_W - 1);
`else
    localparam int FIRST_CTR_ROW = H0;
    localparam int FIRST_CTR_COL = H0;
    localparam int LAST_CTR_ROW  = IMG_H - 1 - H0;
    localparam int LAST_CTR_COL  = IMG_W - 1 - H0;
    localparam logic [7:0] H0_8  = 8'(H0);
`endif

    localparam logic [7:0] FIRST_ROW = 8'(FIRST_CTR_ROW);
    localparam logic [7:0] FIRST_COL = 8'(FIRST_CTR_COL);
    localparam logic [7:0] LAST_ROW  = 8'(LAST_CTR_ROW);
    localparam logic [7:0] LAST_COL  = 8'(LAST_CTR_COL);
    localparam logic [7:0] WIN_LAST  = 8'(WIN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_SLIDE,
        ST_ROWEND,
        ST_DONE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [7:0] ctr_row;
    logic [7:0] ctr_col;
    logic [7:0] row_off;
    logic [7:0] prime_idx;
    logic       col_active;

    logic       fetching;
    logic       hs;
    logic       last_pix;
    logic       col_done;
    logic       win_done;
    logic       row_done;
    logic [7:0] win_col;
    logic [7:0] frow_c;
    logic [7:0] fcol_c;

    // Handshake and column/window/row completion decode. A column that has issued
    // its first request keeps going even if dp_ready drops.
    always_comb begin
        fetching = (state == ST_PRIME) || (state == ST_SLIDE);
        rd_req   = fetching && (col_active || dp_ready);
        hs       = rd_req && rd_ack;
        last_pix = (row_off == WIN_LAST);
        col_done = hs && last_pix;
        win_done = col_done && ((state == ST_SLIDE) || (prime_idx == WIN_LAST));
        win_col  = (state == ST_SLIDE) ? (ctr_col + 8'd1) : ctr_col;
        row_done = win_done && (win_col == LAST_COL);
    end

`ifdef BLFT_BORDER_REPLICATE_EN
    logic signed [9:0] frow_s;
    logic signed [9:0] fcol_s;

    // Window pixel coordinate in signed form, clamped onto the image edge.
    always_comb begin
        frow_s = $signed({2'b00, ctr_row}) - H0_S + $signed({2'b00, row_off});
        if (state == ST_SLIDE) begin
            fcol_s = $signed({2'b00, ctr_col}) + H0_S + 10'sd1;
        end else begin
            fcol_s = $signed({2'b00, ctr_col}) - H0_S + $signed({2'b00, prime_idx});
        end
        if (frow_s < 10'sd0) begin
            frow_c = 8'd0;
        end else if (frow_s > ROW_MAX_S) begin
            frow_c = ROW_MAX_8;
        end else begin
            frow_c = frow_s[7:0];
        end
        if (fcol_s < 10'sd0) begin
            fcol_c = 8'd0;
        end else if (fcol_s > COL_MAX_S) begin
            fcol_c = COL_MAX_8;
        end else begin
            fcol_c = fcol_s[7:0];
        end
    end
`else
    // Window pixel coordinate; centres keep H0 away from every edge, so it stays in range.
    always_comb begin
        frow_c = ctr_row - H0_8 + row_off;
        if (state == ST_SLIDE) begin
            fcol_c = ctr_col + H0_8 + 8'd1;
        end else begin
            fcol_c = ctr_col - H0_8 + prime_idx;
        end
    end
`endif

    assign rd_addr = fetching ? {frow_c, fcol_c} : 16'h0000;
    assign busy    = (state == ST_PRIME) || (state == ST_SLIDE) || (state == ST_ROWEND);
    assign done    = (state == ST_DONE);

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: prime a full window, slide one column at a time, then step rows.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_PRIME;
            ST_PRIME:  if (win_done) next_state = row_done ? ST_ROWEND : ST_SLIDE;
            ST_SLIDE:  if (row_done) next_state = ST_ROWEND;
            ST_ROWEND: next_state = (ctr_row == LAST_ROW) ? ST_DONE : ST_PRIME;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Raster counters: centre row/col, row offset within a column, column index while priming.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ctr_row    <= 8'd0;
            ctr_col    <= 8'd0;
            row_off    <= 8'd0;
            prime_idx  <= 8'd0;
            col_active <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ctr_row    <= FIRST_ROW;
                        ctr_col    <= FIRST_COL;
                        row_off    <= 8'd0;
                        prime_idx  <= 8'd0;
                        col_active <= 1'b0;
                    end
                end
                ST_PRIME, ST_SLIDE: begin
                    if (rd_req) begin
                        col_active <= !(rd_ack && last_pix);
                    end
                    if (hs) begin
                        row_off <= last_pix ? 8'd0 : (row_off + 8'd1);
                    end
                    if (col_done && (state == ST_PRIME)) begin
                        prime_idx <= (prime_idx == WIN_LAST) ? 8'd0 : (prime_idx + 8'd1);
                    end
                    if (win_done && (state == ST_SLIDE)) begin
                        ctr_col <= win_col;
                    end
                end
                ST_ROWEND: begin
                    if (ctr_row != LAST_ROW) begin
                        ctr_row   <= ctr_row + 8'd1;
                        ctr_col   <= FIRST_COL;
                        prime_idx <= 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered datapath outputs, one cycle after the accepted read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_valid     <= 1'b0;
            pix_data      <= 8'h00;
            pix_col_end   <= 1'b0;
            pix_win_start <= 1'b0;
            ctr_valid     <= 1'b0;
            ctr_addr      <= 16'h0000;
        end else begin
            pix_valid     <= hs;
            pix_data      <= hs ? rd_data : 8'h00;
            pix_col_end   <= col_done;
            pix_win_start <= hs && (state == ST_PRIME) && (prime_idx == 8'd0) && (row_off == 8'd0);
            ctr_valid     <= win_done;
            ctr_addr      <= win_done ? {ctr_row, win_col} : 16'h0000;
        end
    end

endmodule
